dsp_mac_slice: RTL and testbench

Parametrised signed multiply-accumulate slice and the next generation of the team's DSP slice. It adds configurable operand widths and multiplier pipeline depth, a per-sample opmode carried alongside the data, a valid/last sideband, saturating accumulation with a sticky overflow flag, and a masked pattern detector. It sits in FIR and correlator datapaths where one instance handles one tap or one accumulation lane.

---
 rtl/dsp_mac_pkg.sv | 32 +++
 rtl/dsp_mult_pipe.sv | 83 ++++++++
 rtl/dsp_mac_slice.sv | 142 ++++++++++++++
 tb/tb_dsp_mac_slice.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_mac_pkg.sv
// Shared opmode field positions, Z-select encoding and the result
// narrowing helper for the DSP multiply-accumulate slice.
package dsp_mac_pkg;

  localparam int unsigned OP_PRE_EN   = 0;
  localparam int unsigned OP_PRE_SUB  = 1;
  localparam int unsigned OP_Z_LO     = 2;
  localparam int unsigned OP_POST_SUB = 4;

  // Widest accumulator the narrowing helper supports.
  localparam int unsigned MAX_P_W = 64;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    C    = 2'd1,
    ACC  = 2'd2,
    RSVD = 2'd3
  } z_sel_e;

  // Narrow a sign-extended (pw+1)-bit sum to pw bits, clamping when the
  // two top bits of the true sum disagree and sat is set.
  function automatic logic [MAX_P_W-1:0] sat_trunc(input logic [MAX_P_W:0] s,
                                                   input int unsigned     pw,
                                                   input logic            sat);
    logic [MAX_P_W-1:0] pmax;
    pmax = (MAX_P_W'(1) << (pw - 1)) - MAX_P_W'(1);
    if (sat && (s[pw] != s[pw-1]))
      return s[pw] ? ~pmax : pmax;
    return s[MAX_P_W-1:0];
  endfunction

endpackage

// File: rtl/dsp_mult_pipe.sv
// Pre-adder and signed multiplier followed by an M_STAGES delay line that
// keeps valid, last, post-stage opmode bits and c aligned with the product.
module dsp_mult_pipe
  import dsp_mac_pkg::*;
#(
  parameter int unsigned A_W      = 18,
  parameter int unsigned B_W      = 18,
  parameter int unsigned C_W      = 48,
  parameter int unsigned M_STAGES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [4:0]           opmode,
  input  logic [A_W-1:0]       a,
  input  logic [B_W-1:0]       b,
  input  logic [B_W-1:0]       d,
  input  logic [C_W-1:0]       c,
  output logic                 m_valid,
  output logic                 m_last,
  output logic [2:0]           m_post_op,
  output logic [C_W-1:0]       m_c,
  output logic [A_W+B_W:0]     m_prod
);

  localparam int unsigned M_W = A_W + B_W + 1;

  logic signed [B_W:0]   bx, dx, bp;
  logic signed [M_W-1:0] prod;

  logic           v_q  [M_STAGES];
  logic           l_q  [M_STAGES];
  logic [2:0]     op_q [M_STAGES];
  logic [C_W-1:0] c_q  [M_STAGES];
  logic [M_W-1:0] m_q  [M_STAGES];

  always_comb begin
    bx = $signed({b[B_W-1], b});
    dx = $signed({d[B_W-1], d});
    bp = bx;
    if (opmode[OP_PRE_EN])
      bp = opmode[OP_PRE_SUB] ? (dx - bx) : (dx + bx);
    prod = $signed({{(B_W+1){a[A_W-1]}}, a}) * $signed({{A_W{bp[B_W]}}, bp});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < M_STAGES; i++) begin
        v_q[i]  <= 1'b0;
        l_q[i]  <= 1'b0;
        op_q[i] <= '0;
        c_q[i]  <= '0;
        m_q[i]  <= '0;
      end
    end else if (clr) begin
      for (int unsigned i = 0; i < M_STAGES; i++)
        v_q[i] <= 1'b0;
    end else if (ce) begin
      v_q[0]  <= in_valid;
      l_q[0]  <= in_last;
      op_q[0] <= opmode[4:2];
      c_q[0]  <= c;
      m_q[0]  <= prod;
      for (int unsigned i = 1; i < M_STAGES; i++) begin
        v_q[i]  <= v_q[i-1];
        l_q[i]  <= l_q[i-1];
        op_q[i] <= op_q[i-1];
        c_q[i]  <= c_q[i-1];
        m_q[i]  <= m_q[i-1];
      end
    end
  end

  assign m_valid   = v_q[M_STAGES-1];
  assign m_last    = l_q[M_STAGES-1];
  assign m_post_op = op_q[M_STAGES-1];
  assign m_c       = c_q[M_STAGES-1];
  assign m_prod    = m_q[M_STAGES-1];

endmodule

// File: rtl/dsp_mac_slice.sv
// Signed multiply-accumulate slice: input register, multiplier pipe, Z mux,
// saturating post adder, P register with sticky overflow and pattern match.
module dsp_mac_slice
  import dsp_mac_pkg::*;
#(
  parameter int unsigned    A_W      = 18,
  parameter int unsigned    B_W      = 18,
  parameter int unsigned    C_W      = 48,
  parameter int unsigned    P_W      = 48,
  parameter int unsigned    M_STAGES = 1,
  parameter int unsigned    SATURATE = 1,
  parameter logic [P_W-1:0] PATTERN  = '0,
  parameter logic [P_W-1:0] MASK     = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  input  logic           clr,
  input  logic           in_valid,
  input  logic           in_last,
  input  logic [4:0]     opmode,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  input  logic [B_W-1:0] d,
  input  logic [C_W-1:0] c,
  output logic           out_valid,
  output logic           out_last,
  output logic [P_W-1:0] p,
  output logic           overflow,
  output logic           pattern_det
);

  logic           v_q, l_q;
  logic [4:0]     op_q;
  logic [A_W-1:0] a_q;
  logic [B_W-1:0] b_q, d_q;
  logic [C_W-1:0] c_q;

  logic             m_valid, m_last;
  logic [2:0]       m_post_op;
  logic [C_W-1:0]   m_c;
  logic [A_W+B_W:0] m_prod;

  logic             pv_q, last_q, ovf_q, pat_q;
  logic [P_W-1:0]   p_q, p_next;
  logic signed [P_W:0] z, m_ext, sum;
  logic             ovf, pat_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= 1'b0;
      l_q  <= 1'b0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      d_q  <= '0;
      c_q  <= '0;
    end else if (clr) begin
      v_q <= 1'b0;
    end else if (ce) begin
      v_q  <= in_valid;
      l_q  <= in_last;
      op_q <= opmode;
      a_q  <= a;
      b_q  <= b;
      d_q  <= d;
      c_q  <= c;
    end
  end

  dsp_mult_pipe #(
    .A_W      (A_W),
    .B_W      (B_W),
    .C_W      (C_W),
    .M_STAGES (M_STAGES)
  ) u_mult (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .clr       (clr),
    .in_valid  (v_q),
    .in_last   (l_q),
    .opmode    (op_q),
    .a         (a_q),
    .b         (b_q),
    .d         (d_q),
    .c         (c_q),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_post_op (m_post_op),
    .m_c       (m_c),
    .m_prod    (m_prod)
  );

  // m_post_op carries opmode[4:2]: Z select in [1:0], post subtract in [2].
  always_comb begin
    z = '0;
    unique case (z_sel_e'(m_post_op[1:0]))
      ZERO:    z = '0;
      C:       z = (P_W+1)'($signed(m_c));
      ACC:     z = (P_W+1)'($signed(p_q));
      default: z = '0;
    endcase
    m_ext    = (P_W+1)'($signed(m_prod));
    sum      = m_post_op[OP_POST_SUB-OP_Z_LO] ? (z - m_ext) : (z + m_ext);
    ovf      = sum[P_W] ^ sum[P_W-1];
    p_next   = P_W'(sat_trunc((MAX_P_W+1)'(sum), P_W, SATURATE != 0));
    pat_next = ((p_next ^ PATTERN) & ~MASK) == '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q   <= 1'b0;
      last_q <= 1'b0;
      p_q    <= '0;
      ovf_q  <= 1'b0;
      pat_q  <= 1'b0;
    end else if (clr) begin
      pv_q   <= 1'b0;
      last_q <= 1'b0;
      p_q    <= '0;
      ovf_q  <= 1'b0;
      pat_q  <= 1'b0;
    end else if (ce) begin
      pv_q   <= m_valid;
      last_q <= m_valid & m_last;
      if (m_valid) begin
        p_q   <= p_next;
        pat_q <= pat_next;
        if (ovf)
          ovf_q <= 1'b1;
      end
    end
  end

  assign out_valid   = pv_q & ce;
  assign out_last    = last_q;
  assign p           = p_q;
  assign overflow    = ovf_q;
  assign pattern_det = pat_q;

endmodule

// File: tb/tb_dsp_mac_slice.sv
// Directed bench for dsp_mac_slice: default-width instance plus 40-bit
// saturating and wrapping instances fed from the same stimulus.
module tb_dsp_mac_slice;

  logic        clk = 1'b0;
  logic        rst_n, ce, clr, in_valid, in_last;
  logic [4:0]  opmode;
  logic [17:0] a, b, d;
  logic [47:0] c;

  logic        ov0, ol0, of0, pd0;
  logic [47:0] p0;
  logic        ov1, ol1, of1, pd1;
  logic [39:0] p1;
  logic        ov2, ol2, of2, pd2;
  logic [39:0] p2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dsp_mac_slice dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr), .in_valid(in_valid),
    .in_last(in_last), .opmode(opmode), .a(a), .b(b), .d(d), .c(c),
    .out_valid(ov0), .out_last(ol0), .p(p0), .overflow(of0), .pattern_det(pd0)
  );

  dsp_mac_slice #(.C_W(40), .P_W(40), .SATURATE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr), .in_valid(in_valid),
    .in_last(in_last), .opmode(opmode), .a(a), .b(b), .d(d), .c(c[39:0]),
    .out_valid(ov1), .out_last(ol1), .p(p1), .overflow(of1), .pattern_det(pd1)
  );

  dsp_mac_slice #(.C_W(40), .P_W(40), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .ce(ce), .clr(clr), .in_valid(in_valid),
    .in_last(in_last), .opmode(opmode), .a(a), .b(b), .d(d), .c(c[39:0]),
    .out_valid(ov2), .out_last(ol2), .p(p2), .overflow(of2), .pattern_det(pd2)
  );

  typedef struct {
    logic [4:0] op;
    longint     av, bv, dv, cv;
    longint     ep;
  } vec_t;

  vec_t tbl[11];

  localparam longint SAT_MAX = 64'sd549755813887;   // 2^39-1
  localparam longint BIGA    = 64'sd131071;         // 2^17-1

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] m48(input longint v);
    logic [63:0] t;
    t = v;
    return {16'h0, t[47:0]};
  endfunction

  function automatic logic [63:0] m40(input longint v);
    logic [63:0] t;
    t = v;
    return {24'h0, t[39:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic l, input logic [4:0] op,
                     input longint av, input longint bv, input longint dv, input longint cv);
    in_valid = v;
    in_last  = l;
    opmode   = op;
    a        = 18'(av);
    b        = 18'(bv);
    d        = 18'(dv);
    c        = 48'(cv);
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 5'd0, 0, 0, 0, 0);
  endtask

  initial begin
    longint acc_s, acc_w, m;
    longint exp_p[4];
    int     idx, ngot;

    tbl[0]  = '{5'b00000,      3,      -4,  0,    0, -12};
    tbl[1]  = '{5'b00000, -131072, -131072,  0,    0, 64'sd17179869184};
    tbl[2]  = '{5'b00011,      5,       2, 10,    0, 40};
    tbl[3]  = '{5'b00001,      5,       2, 10,    0, 60};
    tbl[4]  = '{5'b10101,      5,       2, 10,  100, 40};
    tbl[5]  = '{5'b01100,      2,       3,  0, 1000, 6};
    tbl[6]  = '{5'b00100,     -3,       5,  0,  -20, -35};
    tbl[7]  = '{5'b00001,     -4,      -6,  1,    0, 20};
    tbl[8]  = '{5'b00000,      0,       5,  0,    0, 0};
    tbl[9]  = '{5'b10100,      6,       7,  0,   50, 8};
    tbl[10] = '{5'b00111,     -3,       4, -6,    1, 31};

    rst_n = 1'b0; ce = 1'b1; clr = 1'b0;
    idle();
    tick(); tick();
    chk("reset_outputs", {59'd0, ov0, ol0, of0, pd0, |p0}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Single-sample vectors: output pulse appears after the third edge.
    for (int i = 0; i < 11; i++) begin
      drv(1'b1, 1'b0, tbl[i].op, tbl[i].av, tbl[i].bv, tbl[i].dv, tbl[i].cv);
      tick();
      idle();
      tick();
      chk($sformatf("vec%0d_early", i), {63'd0, ov0}, 64'd0);
      tick();
      chk($sformatf("vec%0d_valid", i), {63'd0, ov0}, 64'd1);
      chk($sformatf("vec%0d_p", i), {16'h0, p0}, m48(tbl[i].ep));
      chk($sformatf("vec%0d_pat", i), {63'd0, pd0}, {63'd0, tbl[i].ep == 0});
      tick();
      chk($sformatf("vec%0d_pulse_end", i), {63'd0, ov0}, 64'd0);
    end
    chk("no_overflow_default", {63'd0, of0}, 64'd0);

    // Back-to-back accumulate, last tag on the fourth sample.
    exp_p = '{1, 3, 6, 10};
    for (int t = 1; t <= 6; t++) begin
      if (t <= 4)
        drv(1'b1, t == 4, (t == 1) ? 5'b00000 : 5'b01000, t, 1, 0, 0);
      else
        idle();
      tick();
      if (t >= 3) begin
        chk($sformatf("acc%0d_valid", t - 3), {63'd0, ov0}, 64'd1);
        chk($sformatf("acc%0d_p", t - 3), {16'h0, p0}, m48(exp_p[t-3]));
        chk($sformatf("acc%0d_last", t - 3), {63'd0, ol0}, {63'd0, t == 6});
      end
    end
    tick();
    chk("acc_done", {62'd0, ov0, ol0}, 64'd0);

    // Pattern detect: p goes 5 -> 0 -> (bubbles) -> 1.
    drv(1'b1, 1'b0, 5'b00000, 5, 1, 0, 0); tick();
    drv(1'b1, 1'b0, 5'b11000, 5, 1, 0, 0); tick();
    idle(); tick();
    chk("pat_s0", {15'd0, ov0, p0}, {15'd0, 1'b1, 48'd5});
    chk("pat_s0_det", {63'd0, pd0}, 64'd0);
    tick();
    chk("pat_s1", {15'd0, ov0, p0}, {15'd0, 1'b1, 48'd0});
    chk("pat_s1_det", {63'd0, pd0}, 64'd1);
    drv(1'b1, 1'b0, 5'b01000, 1, 1, 0, 0); tick();
    idle();
    chk("pat_bubble", {15'd0, ov0, p0}, {15'd0, 1'b0, 48'd0});
    chk("pat_bubble_det", {63'd0, pd0}, 64'd1);
    tick(); tick();
    chk("pat_s2", {15'd0, ov0, p0}, {15'd0, 1'b1, 48'd1});
    chk("pat_s2_det", {63'd0, pd0}, 64'd0);
    tick();

    // Long accumulation of near-full-scale products on the 40-bit slices.
    acc_s = 0; acc_w = 0;
    m = BIGA * BIGA;
    for (int t = 1; t <= 42; t++) begin
      if (t <= 40)
        drv(1'b1, 1'b0, (t == 1) ? 5'b00000 : 5'b01000, BIGA, BIGA, 0, 0);
      else
        idle();
      tick();
      if (t >= 3) begin
        acc_s = (acc_s + m > SAT_MAX) ? SAT_MAX : acc_s + m;
        acc_w = ((acc_w + m) <<< 24) >>> 24;
        chk($sformatf("sat_p%0d", t - 3), {24'h0, p1}, m40(acc_s));
        chk($sformatf("wrap_p%0d", t - 3), {24'h0, p2}, m40(acc_w));
      end
    end
    chk("sat_clamped", {24'h0, p1}, m40(SAT_MAX));
    chk("sat_ovf", {63'd0, of1}, 64'd1);
    chk("wrap_negative", {63'd0, p2[39]}, 64'd1);
    chk("wrap_ovf", {63'd0, of2}, 64'd1);

    drv(1'b1, 1'b0, 5'b00000, 1, 1, 0, 0); tick();
    idle(); tick(); tick();
    chk("sat_fresh_p", {24'h0, p1}, 64'd1);
    chk("sat_ovf_sticky", {63'd0, of1}, 64'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_sat", {23'd0, of1, p1}, 64'd0);
    chk("clr_wrap", {23'd0, of2, p2}, 64'd0);

    // Flush: two samples in flight plus a concurrent one during clr.
    drv(1'b1, 1'b0, 5'b00000, 7, 1, 0, 0); tick();
    drv(1'b1, 1'b0, 5'b00000, 8, 1, 0, 0); tick();
    drv(1'b1, 1'b0, 5'b00000, 9, 1, 0, 0); clr = 1'b1; tick();
    clr = 1'b0; idle();
    for (int t = 0; t < 5; t++) begin
      tick();
      chk($sformatf("flush_quiet%0d", t), {15'd0, ov0, p0}, 64'd0);
    end

    // ce stall for 5 cycles with in_valid held high.
    idx = 0; ngot = 0;
    for (int t = 0; t < 20; t++) begin
      ce = !(t >= 3 && t < 8);
      if (idx < 6) drv(1'b1, 1'b0, 5'b00000, idx + 1, 1, 0, 0);
      else idle();
      tick();
      if (ce && idx < 6) idx++;
      if (ov0) begin
        if (ngot < 6) chk($sformatf("stall_p%0d", ngot), {16'h0, p0}, 64'(ngot + 1));
        ngot++;
      end
    end
    ce = 1'b1;
    chk("stall_count", 64'(ngot), 64'd6);

    // Asynchronous reset while a result is on the output.
    drv(1'b1, 1'b0, 5'b00000, 3, -4, 0, 0); tick();
    idle(); tick(); tick();
    chk("rst_pre_valid", {63'd0, ov0}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst", {59'd0, ov0, ol0, of0, pd0, |p0}, 64'd0);
    tick();
    rst_n = 1'b1;
    drv(1'b1, 1'b0, 5'b00000, 2, 3, 0, 0); tick();
    idle(); tick();
    chk("post_rst_early", {63'd0, ov0}, 64'd0);
    tick();
    chk("post_rst_result", {15'd0, ov0, p0}, {15'd0, 1'b1, 48'd6});
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
